// File: rtl/zbt_to_display_if.sv
// ZBT read-port bundle between the display fetch engine (master) and the SRAM (slave).
interface zbt_to_display_if;
  logic [18:0] vram_addr;
  logic        vram_we;
  logic [35:0] vram_read_data;

  modport master (
    output vram_addr,
    output vram_we,
    input  vram_read_data
  );

  modport slave (
    input  vram_addr,
    input  vram_we,
    output vram_read_data
  );
endinterface

// File: rtl/zbt_to_display.sv
// Streams two-pixel ZBT words out as one registered 18-bit pixel per clock, with prefetch.
// Optional generated test pattern: define VRAM_TESTPAT_EN.
module zbt_to_display #(
  parameter logic [10:0] H_ACTIVE    = 11'd1024,
  parameter logic [9:0]  V_ACTIVE    = 10'd768,
  parameter logic [10:0] FETCH_AHEAD = 11'd4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               test_mode,
  zbt_to_display_if.master   zbt,
  output logic [17:0]        vr_pixel,
  output logic               vr_pixel_valid,
  output logic [7:0]         frame_count
);

  logic [10:0] hf_s;
  logic        active_s;
  logic [17:0] pixel_next_s;
  logic        unused_s;

  logic [18:0] vram_addr_r;
  logic [35:0] word_r;
  logic [17:0] vr_pixel_r;
  logic        vr_pixel_valid_r;
  logic [7:0]  frame_count_r;
  logic [9:0]  vcount_prev_r;

  // Prefetch column wraps modulo 2^11; a line wrap still fetches from the current vcount.
  assign hf_s     = hcount + FETCH_AHEAD;
  assign active_s = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);

`ifdef VRAM_TESTPAT_EN
  assign unused_s = hf_s[10];

  // Next pixel: generated pattern or the half of the captured word matching hcount parity.
  always_comb begin
    pixel_next_s = 18'd0;
    if (!active_s) begin
      pixel_next_s = 18'd0;
    end else if (test_mode) begin
      pixel_next_s = {hcount[7:2], vcount[7:2], hcount[5:0] ^ vcount[5:0]};
    end else if (hcount[0]) begin
      pixel_next_s = word_r[17:0];
    end else begin
      pixel_next_s = word_r[35:18];
    end
  end
`else
  assign unused_s = hf_s[10] ^ test_mode;

  // Next pixel: the half of the captured word matching hcount parity, black outside the active area.
  always_comb begin
    pixel_next_s = 18'd0;
    if (!active_s) begin
      pixel_next_s = 18'd0;
    end else if (hcount[0]) begin
      pixel_next_s = word_r[17:0];
    end else begin
      pixel_next_s = word_r[35:18];
    end
  end
`endif

  // Address, word capture, pixel output and frame counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_addr_r      <= 19'd0;
      word_r           <= 36'd0;
      vr_pixel_r       <= 18'd0;
      vr_pixel_valid_r <= 1'b0;
      frame_count_r    <= 8'd0;
      vcount_prev_r    <= 10'd0;
    end else begin
      vram_addr_r      <= {vcount, hf_s[9:1]};
      // Odd-column capture lands the word holding pixels hcount+1 and hcount+2.
      if (hcount[0]) begin
        word_r <= zbt.vram_read_data;
      end
      vr_pixel_r       <= pixel_next_s;
      vr_pixel_valid_r <= active_s;
      vcount_prev_r    <= vcount;
      if ((vcount_prev_r != 10'd0) && (vcount == 10'd0)) begin
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  assign zbt.vram_addr  = vram_addr_r;
  assign zbt.vram_we    = 1'b0;
  assign vr_pixel       = vr_pixel_r;
  assign vr_pixel_valid = vr_pixel_valid_r;
  assign frame_count    = frame_count_r;

endmodule

// File: tb/tb_zbt_to_display.sv
// Directed bench for zbt_to_display: vector table for address/pixel/blanking, plus reset and frame sequences.
module tb_zbt_to_display;

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    logic        tm;
    logic        chk;
    logic [17:0] pix;
    logic        val;
    logic [18:0] addr;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        test_mode;
  logic [17:0] vr_pixel;
  logic        vr_pixel_valid;
  logic [7:0]  frame_count;
  logic [35:0] zd1;

  int tests;
  int fails;
  vec_t vecs[$];

  zbt_to_display_if zbt ();

  zbt_to_display dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hcount         (hcount),
    .vcount         (vcount),
    .test_mode      (test_mode),
    .zbt            (zbt.master),
    .vr_pixel       (vr_pixel),
    .vr_pixel_valid (vr_pixel_valid),
    .frame_count    (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents as a function of address, with one hand-placed word.
  function automatic logic [35:0] word_of(input logic [18:0] a);
    if (a == {10'd5, 9'd52}) return {18'h12345, 18'h2ABCD};
    return {1'b0, a[16:0], 1'b1, a[16:0]};
  endfunction

  // ZBT model: read data appears two clocks after the address.
  always @(posedge clk) begin
    zd1                <= word_of(zbt.vram_addr);
    zbt.vram_read_data <= zd1;
  end

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One contiguous run of columns on one line; the first 'warm' active pixels depend on earlier history.
  task automatic add_seg(input logic [10:0] h0, input int n, input logic [9:0] v,
                         input logic tm, input int warm);
    for (int i = 0; i < n; i++) begin
      vec_t r;
      logic [10:0] hh;
      logic [10:0] hf;
      logic [35:0] w;
      logic act;
      hh = h0 + 11'(i);
      hf = hh + 11'd4;
      act = (hh < 11'd1024) && (v < 10'd768);
      w = word_of({v, hh[9:1]});
      r.h = hh;
      r.v = v;
      r.tm = tm;
      r.val = act;
      r.addr = {v, hf[9:1]};
      r.chk = (i >= warm) || !act;
      r.pix = act ? (hh[0] ? w[17:0] : w[35:18]) : 18'd0;
`ifdef VRAM_TESTPAT_EN
      if (tm && act) r.pix = {hh[7:2], v[7:2], hh[5:0] ^ v[5:0]};
`endif
      vecs.push_back(r);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b1;
    hcount = 11'd0;
    vcount = 10'd0;
    test_mode = 1'b0;

    add_seg(11'd96,   16, 10'd5,   1'b0, 4);
    add_seg(11'd1016, 16, 10'd10,  1'b0, 4);
    add_seg(11'd1336, 9,  10'd10,  1'b0, 0);
    add_seg(11'd2044, 12, 10'd3,   1'b0, 4);
    add_seg(11'd14,   12, 10'd8,   1'b1, 4);
    add_seg(11'd300,  8,  10'd767, 1'b0, 4);
    add_seg(11'd300,  6,  10'd768, 1'b0, 0);

    // Power-on reset.
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr",  {17'd0, zbt.vram_addr}, 36'd0);
    chk("rst_we",    {35'd0, zbt.vram_we}, 36'd0);
    chk("rst_pixel", {18'd0, vr_pixel}, 36'd0);
    chk("rst_valid", {35'd0, vr_pixel_valid}, 36'd0);
    chk("rst_frame", {28'd0, frame_count}, 36'd0);
    reset_n = 1'b1;

    // Vector table: drive on the falling edge, check one clock later.
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        vec_t p;
        p = vecs[i-1];
        chk($sformatf("addr h=%0d v=%0d", p.h, p.v), {17'd0, zbt.vram_addr}, {17'd0, p.addr});
        chk($sformatf("valid h=%0d v=%0d", p.h, p.v), {35'd0, vr_pixel_valid}, {35'd0, p.val});
        chk("we", {35'd0, zbt.vram_we}, 36'd0);
        if (p.chk) chk($sformatf("pixel h=%0d v=%0d", p.h, p.v), {18'd0, vr_pixel}, {18'd0, p.pix});
      end
      if (i < vecs.size()) begin
        hcount = vecs[i].h;
        vcount = vecs[i].v;
        test_mode = vecs[i].tm;
      end
    end

    // Frame counter: clean start, three full frames, then wrap through 255.
    test_mode = 1'b0;
    hcount = 11'd0;
    vcount = 10'd0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("frame_start", {28'd0, frame_count}, 36'd0);
    for (int f = 1; f <= 3; f++) begin
      for (int v = 1; v <= 805; v++) begin
        vcount = 10'(v);
        @(negedge clk);
      end
      chk($sformatf("frame_mid%0d", f), {28'd0, frame_count}, 36'(f - 1));
      vcount = 10'd0;
      @(negedge clk);
      chk($sformatf("frame_end%0d", f), {28'd0, frame_count}, 36'(f));
    end
    for (int k = 4; k <= 255; k++) begin
      vcount = 10'd1;
      @(negedge clk);
      vcount = 10'd0;
      @(negedge clk);
    end
    @(negedge clk);
    chk("frame_255", {28'd0, frame_count}, 36'd255);
    vcount = 10'd1;
    @(negedge clk);
    vcount = 10'd0;
    @(negedge clk);
    @(negedge clk);
    chk("frame_wrap", {28'd0, frame_count}, 36'd0);
    vcount = 10'd1;
    @(negedge clk);
    vcount = 10'd0;
    @(negedge clk);
    @(negedge clk);
    chk("frame_after_wrap", {28'd0, frame_count}, 36'd1);

    // Mid-line reset: outputs clear at once, pixels stay black until the next odd-column capture.
    vcount = 10'd5;
    for (int h = 190; h < 200; h++) begin
      hcount = 11'(h);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_addr",  {17'd0, zbt.vram_addr}, 36'd0);
    chk("mid_rst_pixel", {18'd0, vr_pixel}, 36'd0);
    chk("mid_rst_valid", {35'd0, vr_pixel_valid}, 36'd0);
    chk("mid_rst_frame", {28'd0, frame_count}, 36'd0);
    chk("mid_rst_we",    {35'd0, zbt.vram_we}, 36'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hcount = 11'd200;
    @(negedge clk);
    chk("post_rst_pixel200", {18'd0, vr_pixel}, 36'd0);
    chk("post_rst_valid",    {35'd0, vr_pixel_valid}, 36'd1);
    chk("post_rst_addr",     {17'd0, zbt.vram_addr}, {17'd0, 10'd5, 9'd102});
    hcount = 11'd201;
    @(negedge clk);
    chk("post_rst_pixel201", {18'd0, vr_pixel}, 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
